// File: rtl/keysw_responder.sv
// keysw_responder: memory-mapped KEY/SW input responder on the MEM-stage bus.
// Each bank: 2-flop synchroniser, stability counter, debounced data register,
// sticky ready/overrun flags cleared by data reads or control writes.
// Optional feature macro: KEYSW_IRQ_EN (interrupt enables and irq output).
// Bus handshake: there is no valid/ready pair; a register access is the one-cycle
// strobe `re` or `we` qualified by a decoded `addr`. `sel`/`rdata` are combinational
// from `addr`, and all side effects land on the rising edge where the strobe is high.

module keysw_bank #(
  parameter int W  = 4,
  parameter int DC = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw,
  input  logic         ctrl_wr,
  input  logic         data_rd,
  input  logic         wr_ready,
  input  logic         wr_overrun,
  input  logic         wr_ie,
  output logic [W-1:0] d,
  output logic         ready,
  output logic         overrun,
  output logic         ie
);

  localparam int CW = $clog2(DC + 1);

  logic [W-1:0]  sync1;
  logic [W-1:0]  s;
  logic [CW-1:0] cnt;
  logic          evt;
  logic          ready_n;
  logic          overrun_n;

  // cnt holds how many cycles `s` has kept its current value. The comparison
  // looks at sync1 (the value about to enter `s`) so cnt is already 0 in the
  // first cycle `s` shows a new value.
  assign evt = (cnt == CW'(DC)) && (s != d);

  // Synchroniser, stability counter and debounced register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      s     <= '0;
      cnt   <= '0;
      d     <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      if (sync1 != s)
        cnt <= '0;
      else if (cnt != CW'(DC))
        cnt <= cnt + CW'(1);
      if (evt)
        d <= s;
    end
  end

  // Sticky flag next state: bus clears first, then a same-edge event wins.
  // A colliding data read already returned the old value, so it is not an overrun.
  always_comb begin
    ready_n   = ready;
    overrun_n = overrun;
    if (ctrl_wr) begin
      ready_n   = ready & wr_ready;
      overrun_n = overrun & wr_overrun;
    end else if (data_rd) begin
      ready_n   = 1'b0;
      overrun_n = 1'b0;
    end
    if (evt) begin
      ready_n = 1'b1;
      if (data_rd)
        overrun_n = overrun;
      else
        overrun_n = overrun_n | ready;
    end
  end

  // Sticky flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ready   <= ready_n;
      overrun <= overrun_n;
    end
  end

`ifdef KEYSW_IRQ_EN
  // Interrupt enable, loaded by every control-register write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ie <= 1'b0;
    else if (ctrl_wr)
      ie <= wr_ie;
  end
`else
  logic unused_ie;
  assign unused_ie = wr_ie;
  assign ie = 1'b0;
`endif

endmodule

module keysw_responder #(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDRKEY         = 32'hFFFFF080,
  parameter logic [DBITS-1:0] ADDRSW          = 32'hFFFFF090,
  parameter int               KEYBITS         = 4,
  parameter int               SWBITS          = 10,
  parameter int               DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEYBITS-1:0] KEY,
  input  logic [SWBITS-1:0]  SW,
  input  logic [DBITS-1:0]   addr,
  input  logic [DBITS-1:0]   wdata,
  input  logic               we,
  input  logic               re,
  output logic               sel,
  output logic [DBITS-1:0]   rdata,
  output logic               irq
);

  logic               key_data_hit, key_ctrl_hit, sw_data_hit, sw_ctrl_hit;
  logic [KEYBITS-1:0] key_d;
  logic [SWBITS-1:0]  sw_d;
  logic               key_ready, key_overrun, key_ie;
  logic               sw_ready, sw_overrun, sw_ie;
  logic               unused_wdata;

  assign key_data_hit = (addr == ADDRKEY);
  assign key_ctrl_hit = (addr == ADDRKEY + DBITS'(4));
  assign sw_data_hit  = (addr == ADDRSW);
  assign sw_ctrl_hit  = (addr == ADDRSW + DBITS'(4));
  assign sel          = key_data_hit | key_ctrl_hit | sw_data_hit | sw_ctrl_hit;

  // Only bits 0, 1 and 4 of a control write carry meaning.
  assign unused_wdata = ^{wdata[DBITS-1:5], wdata[3:2]};

  // Pushbuttons are active-low; invert so a press reads 1.
  // A write in the same cycle as a read suppresses the read side effect.
  keysw_bank #(.W(KEYBITS), .DC(DEBOUNCE_CYCLES)) u_key (
    .clk        (clk),
    .reset      (reset),
    .raw        (~KEY),
    .ctrl_wr    (we & key_ctrl_hit),
    .data_rd    (re & ~we & key_data_hit),
    .wr_ready   (wdata[0]),
    .wr_overrun (wdata[1]),
    .wr_ie      (wdata[4]),
    .d          (key_d),
    .ready      (key_ready),
    .overrun    (key_overrun),
    .ie         (key_ie)
  );

  keysw_bank #(.W(SWBITS), .DC(DEBOUNCE_CYCLES)) u_sw (
    .clk        (clk),
    .reset      (reset),
    .raw        (SW),
    .ctrl_wr    (we & sw_ctrl_hit),
    .data_rd    (re & ~we & sw_data_hit),
    .wr_ready   (wdata[0]),
    .wr_overrun (wdata[1]),
    .wr_ie      (wdata[4]),
    .d          (sw_d),
    .ready      (sw_ready),
    .overrun    (sw_overrun),
    .ie         (sw_ie)
  );

  // Combinational read mux; zero when no register is addressed.
  always_comb begin
    rdata = '0;
    if (key_data_hit) begin
      rdata = DBITS'(key_d);
    end else if (sw_data_hit) begin
      rdata = DBITS'(sw_d);
    end else if (key_ctrl_hit) begin
      rdata[0] = key_ready;
      rdata[1] = key_overrun;
      rdata[4] = key_ie;
    end else if (sw_ctrl_hit) begin
      rdata[0] = sw_ready;
      rdata[1] = sw_overrun;
      rdata[4] = sw_ie;
    end
  end

`ifdef KEYSW_IRQ_EN
  assign irq = (key_ready & key_ie) | (sw_ready & sw_ie);
`else
  assign irq = 1'b0;
`endif

endmodule

// File: doc/keysw_responder.md
# keysw_responder

Memory-mapped input responder for the DE0-CV KEY and SW banks on the processor's load/store data bus. It synchronises and debounces the raw board inputs and exposes a data register and a control/status register per bank. Each bank carries sticky ready/overrun flags, and data-register reads clear them as a side effect. It sits beside D-MEM on the MEM-stage bus; the MEM stage selects its read data whenever `sel` is high.

## Interface
- `DBITS`, 32, bus data/address width
- `ADDRKEY`, 32'hFFFFF080, KEY data register address; KEY control at `ADDRKEY+4`
- `ADDRSW`, 32'hFFFFF090, SW data register address; SW control at `ADDRSW+4`
- `KEYBITS`, 4, KEY bank width
- `SWBITS`, 10, SW bank width
- `DEBOUNCE_CYCLES`, 16, required stable cycles before a change is accepted (≥2)

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `KEY`  in  KEYBITS  raw pushbuttons, active-low
- `SW`  in  SWBITS  raw switches, active-high
- `addr`  in  DBITS  bus address
- `wdata`  in  DBITS  bus write data
- `we`  in  1  write strobe, one cycle
- `re`  in  1  read strobe, one cycle
- `sel`  out  1  `addr` hits one of the four registers
- `rdata`  out  DBITS  read data, 0 when `sel`=0
- `irq`  out  1  interrupt request, level

## Operation
- Input conditioning: KEY is inverted first, so pressed reads 1. Each bank then passes through a 2-flop synchroniser, giving `s`.
- Per-bank stability counter `cnt` (width clog2(DEBOUNCE_CYCLES+1)):
  - resets to 0 when `s` differs from its previous-cycle value;
  - otherwise increments, saturating at DEBOUNCE_CYCLES.
- Debounced register `d` loads `s` on the edge where `cnt`==DEBOUNCE_CYCLES and `s`!=`d`. That edge is a bank "event".
- Data register, read-only: `d` zero-extended to DBITS. Writes are ignored.
- Control register, per bank:
  - bit0 `ready`: set by an event.
  - bit1 `overrun`: set by an event while `ready`=1.
  - bit4 `ie`: interrupt enable, read/write.
  - Other bits read 0.
- Control register writes:
  - `ie` ← `wdata[4]`.
  - `ready` and `overrun` clear when the corresponding `wdata` bit is 0. Writing 1 leaves them unchanged.
- Data-register read side effect: `re` with a data-register hit clears that bank's `ready` and `overrun` at the next edge.
- Simultaneous events, same bank, same edge:
  - Event plus data read: `ready`=1, `overrun` unchanged. The event wins; the read returned the pre-event `d`.
  - Event plus control write clearing `ready`: `ready`=1, and `overrun` is set only if `ready` was 1 before the edge.
  - `we` and `re` both high: the write applies and the read side effect is suppressed.
- `irq` = (Kready & Kie) | (Sready & Sie).
- Reset, mid-operation included: synchronisers, `cnt`, `d`, `ready`, `overrun`, `ie` and `irq` all go to 0 immediately. `sel` and `rdata` are combinational and reflect the reset register state. No event is generated on reset release with idle inputs.

## Timing
- Read path is combinational: `rdata`/`sel` are valid in the same cycle as `addr`, and the MEM stage latches the value at that edge.
- Writes and read side effects take effect at the rising edge where the strobe is high.
- Input latency: a raw change held stable appears in `d`, with `ready` set, 2+DEBOUNCE_CYCLES edges after the first edge that samples it.
- A glitch shorter than DEBOUNCE_CYCLES cycles never produces an event.
- `irq` is registered-derived: high the cycle after the event edge, low the cycle after the clearing edge.

## Configuration
- `KEYSW_IRQ_EN` defined: `ie` bits, `irq` logic and the control-register `ie` field are implemented as above.
- Not defined: `irq` is tied 0, the `ie` bits read 0 and writes to them are ignored. `ready`/`overrun` behaviour is unchanged (polled mode).

## Test plan
- Reset/idle: assert `reset` mid-count with KEY=4'hF and SW=0 → all registers read 0, `irq`=0, no event within 50 cycles.
- Debounce (DEBOUNCE_CYCLES=4):
  - KEY←4'hE held → KEY data reads 1 and KEY control reads 1 exactly 6 edges later.
  - KEY toggling 4'hE/4'hF every 2 cycles → no event.
- Overrun: SW←10'h001 then SW←10'h003, no reads → SW control reads 3. Read `ADDRSW` → returns 10'h003; control then reads 0.
- Read/event collision: data read issued on the same edge as a new KEY event → `rdata` returns the old value, `ready` stays 1, `overrun` stays 0.
- Interrupt: write 32'h10 to `ADDRKEY+4`, press KEY[3] → `irq` rises. Write 0 to `ADDRKEY+4` → `irq` falls next cycle. With `KEYSW_IRQ_EN` undefined → `irq` stays 0 and the control register reads 1.
- Decode: `addr`=32'hFFFFF088 → `sel`=0, `rdata`=0. A write to `ADDRSW` → no state change.
